// File: rtl/uart_pkg.sv
// Shared UART constants: threshold-mode encodings and default FIFO geometry
// used by both the TX and RX FIFO instances.
package uart_pkg;

  localparam logic THR_MODE_TX = 1'b0;
  localparam logic THR_MODE_RX = 1'b1;

  localparam int unsigned UART_DATA_W     = 8;
  localparam int unsigned UART_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_fifo_param_if.sv
// Push/pop/status bundle between the register block (master) and the FIFO (slave).
interface uart_fifo_param_if #(
  parameter int unsigned DATA_W = uart_pkg::UART_DATA_W,
  parameter int unsigned DEPTH  = uart_pkg::UART_FIFO_DEPTH
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic              en;
  logic              flush;
  logic              push_in;
  logic              pop_in;
  logic [DATA_W-1:0] din;
  logic              thr_mode;
  logic [AW:0]       threshold;
  logic [DATA_W-1:0] dout;
  logic [AW:0]       level;
  logic              empty;
  logic              full;
  logic              overrun;
  logic              underrun;
  logic              thre_trigger;

  modport master (
    output en, flush, push_in, pop_in, din, thr_mode, threshold,
    input  dout, level, empty, full, overrun, underrun, thre_trigger
  );

  modport slave (
    input  en, flush, push_in, pop_in, din, thr_mode, threshold,
    output dout, level, empty, full, overrun, underrun, thre_trigger
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one async read port.
module uart_fifo_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write port; storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_fifo_param.sv
// Parametrised circular-buffer FIFO for the UART TX and RX paths.
// First-word fall-through read, occupancy level, synchronous flush, registered
// overrun/underrun flags and a direction-selectable threshold trigger.
// Build option: define UART_FIFO_STICKY_ERR_EN to make overrun/underrun sticky
// (set by the event, cleared by flush or rst; set wins over flush).
module uart_fifo_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = UART_DATA_W,
  parameter int unsigned DEPTH  = UART_FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  uart_fifo_param_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW-1:0]     w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [AW:0]       r_level, w_level_nxt;
  logic              r_overrun, r_underrun, r_thre_trigger;
  logic              w_overrun_nxt, w_underrun_nxt, w_thre_nxt;
  logic              w_empty, w_full;
  logic              w_pop_ok, w_push_ok;
  logic              w_ovr_evt, w_unr_evt;
  logic              w_we;
  logic [DATA_W-1:0] w_rdata;

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == (AW+1)'(DEPTH));
  assign w_pop_ok  = bus.en & bus.pop_in & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push_ok = bus.en & bus.push_in & (~w_full | w_pop_ok);
  assign w_ovr_evt = bus.en & bus.push_in & w_full & ~w_pop_ok;
  assign w_unr_evt = bus.en & bus.pop_in & w_empty;
  assign w_we      = w_push_ok & ~bus.flush;

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.din),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Next pointers and level; flush overrides any push/pop in the same cycle.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_level_nxt  = r_level;
    if (bus.flush) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_level_nxt  = '0;
    end else begin
      if (w_push_ok) w_wr_ptr_nxt = r_wr_ptr + AW'(1);
      if (w_pop_ok)  w_rd_ptr_nxt = r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   w_level_nxt = r_level + (AW+1)'(1);
        2'b01:   w_level_nxt = r_level - (AW+1)'(1);
        default: w_level_nxt = r_level;
      endcase
    end
  end

  // Next error flags and threshold compare (compare uses the pre-update level).
  always_comb begin
`ifdef UART_FIFO_STICKY_ERR_EN
    w_overrun_nxt  = w_ovr_evt | (r_overrun & ~bus.flush);
    w_underrun_nxt = w_unr_evt | (r_underrun & ~bus.flush);
`else
    w_overrun_nxt  = w_ovr_evt & ~bus.flush;
    w_underrun_nxt = w_unr_evt & ~bus.flush;
`endif
    if (bus.thr_mode == THR_MODE_RX) begin
      w_thre_nxt = (r_level >= bus.threshold);
    end else begin
      w_thre_nxt = (r_level <= bus.threshold);
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_overrun      <= 1'b0;
      r_underrun     <= 1'b0;
      r_thre_trigger <= 1'b0;
    end else begin
      r_wr_ptr       <= w_wr_ptr_nxt;
      r_rd_ptr       <= w_rd_ptr_nxt;
      r_level        <= w_level_nxt;
      r_overrun      <= w_overrun_nxt;
      r_underrun     <= w_underrun_nxt;
      r_thre_trigger <= w_thre_nxt;
    end
  end

  // Head word is masked to zero while empty so stale storage never leaks out.
  assign bus.dout         = w_empty ? '0 : w_rdata;
  assign bus.level        = r_level;
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.overrun      = r_overrun;
  assign bus.underrun     = r_underrun;
  assign bus.thre_trigger = r_thre_trigger;

endmodule

// File: tb/tb_uart_fifo_param.sv
// Self-checking bench for uart_fifo_param: table of single-cycle vectors plus
// hand-written fill/drain, wrap, threshold, flush and async-reset sequences.
// A queue scoreboard holds expected data and is compared whenever a pop is accepted.
module tb_uart_fifo_param;
  import uart_pkg::*;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AW     = 4;
`ifdef UART_FIFO_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  uart_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  uart_fifo_param #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sb[$];
  bit         m_ovr, m_unr;
  bit         t_mode;
  int         t_thr;

  typedef struct {
    logic       en, fl, pu, po;
    logic [7:0] d;
    int         lvl;
    logic       unr_p, unr_s;
  } vec_t;

  vec_t vt[12];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void setv(input int i, input logic en, input logic fl, input logic pu,
                               input logic po, input logic [7:0] d, input int lvl,
                               input logic unr_p, input logic unr_s);
    vt[i].en = en; vt[i].fl = fl; vt[i].pu = pu; vt[i].po = po; vt[i].d = d;
    vt[i].lvl = lvl; vt[i].unr_p = unr_p; vt[i].unr_s = unr_s;
  endfunction

  task automatic set_thr(input bit m, input int th);
    t_mode        = m;
    t_thr         = th;
    bus.thr_mode  = m;
    bus.threshold = (AW+1)'(th);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "/level"},    32'(bus.level), 32'd0);
    chk({tag, "/empty"},    32'(bus.empty), 32'd1);
    chk({tag, "/full"},     32'(bus.full), 32'd0);
    chk({tag, "/dout"},     32'(bus.dout), 32'd0);
    chk({tag, "/overrun"},  32'(bus.overrun), 32'd0);
    chk({tag, "/underrun"}, 32'(bus.underrun), 32'd0);
    chk({tag, "/thre"},     32'(bus.thre_trigger), 32'd0);
  endtask

  // One clock: called at posedge+1, drives inputs, checks head, steps model, checks state.
  task automatic cyc(input string tag, input logic en, input logic fl, input logic pu,
                     input logic po, input logic [7:0] d);
    int lvl;
    bit pop_ok, push_ok, ovr_evt, unr_evt, exp_thre;
    bus.en = en; bus.flush = fl; bus.push_in = pu; bus.pop_in = po; bus.din = d;
    #1;
    lvl      = sb.size();
    pop_ok   = en && po && (lvl != 0);
    push_ok  = en && pu && ((lvl != DEPTH) || pop_ok);
    ovr_evt  = en && pu && (lvl == DEPTH) && !pop_ok;
    unr_evt  = en && po && (lvl == 0);
    exp_thre = (t_mode == THR_MODE_RX) ? (lvl >= t_thr) : (lvl <= t_thr);
    if (lvl == 0) chk({tag, "/dout"}, 32'(bus.dout), 32'd0);
    else          chk({tag, "/dout"}, 32'(bus.dout), 32'(sb[0]));
    if (fl) begin
      sb.delete();
    end else begin
      if (pop_ok)  void'(sb.pop_front());
      if (push_ok) sb.push_back(d);
    end
    if (STICKY) begin
      m_ovr = ovr_evt | (m_ovr & !fl);
      m_unr = unr_evt | (m_unr & !fl);
    end else begin
      m_ovr = ovr_evt & !fl;
      m_unr = unr_evt & !fl;
    end
    @(posedge clk);
    #1;
    chk({tag, "/level"},    32'(bus.level), 32'(sb.size()));
    chk({tag, "/empty"},    32'(bus.empty), 32'(sb.size() == 0));
    chk({tag, "/full"},     32'(bus.full), 32'(sb.size() == DEPTH));
    chk({tag, "/overrun"},  32'(bus.overrun), 32'(m_ovr));
    chk({tag, "/underrun"}, 32'(bus.underrun), 32'(m_unr));
    chk({tag, "/thre"},     32'(bus.thre_trigger), 32'(exp_thre));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.flush = 1'b0; bus.push_in = 1'b0; bus.pop_in = 1'b0; bus.din = '0;
    set_thr(THR_MODE_RX, 8);
    m_ovr = 1'b0;
    m_unr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    //      i  en fl pu po d      lvl unr_p unr_s
    setv(0,  1, 0, 0, 1, 8'h00, 0,  1,    1);  // pop while empty
    setv(1,  1, 0, 1, 1, 8'hA5, 1,  1,    1);  // push+pop while empty
    setv(2,  1, 0, 1, 0, 8'h3C, 2,  0,    1);
    setv(3,  0, 0, 1, 1, 8'hFF, 2,  0,    1);  // disabled: frozen
    setv(4,  1, 0, 0, 1, 8'h00, 1,  0,    1);
    setv(5,  1, 1, 1, 0, 8'h77, 0,  0,    0);  // flush beats push
    setv(6,  1, 0, 1, 0, 8'h11, 1,  0,    0);
    setv(7,  1, 0, 1, 1, 8'h22, 1,  0,    0);
    setv(8,  1, 1, 0, 1, 8'h00, 0,  0,    0);  // flush beats pop
    setv(9,  1, 1, 0, 1, 8'h00, 0,  0,    1);  // underrun vs flush
    setv(10, 1, 0, 0, 0, 8'h00, 0,  0,    1);
    setv(11, 1, 1, 0, 0, 8'h00, 0,  0,    0);
    for (int i = 0; i < 12; i++) begin
      cyc($sformatf("vec%0d", i), vt[i].en, vt[i].fl, vt[i].pu, vt[i].po, vt[i].d);
      chk($sformatf("vec%0d/tbl_level", i), 32'(bus.level), 32'(vt[i].lvl));
      chk($sformatf("vec%0d/tbl_underrun", i), 32'(bus.underrun),
          32'(STICKY ? vt[i].unr_s : vt[i].unr_p));
    end

    // Fill 0x01..0x10 with RX threshold 8, then overrun, then drain in order.
    set_thr(THR_MODE_RX, 8);
    for (int i = 1; i <= 16; i++) begin
      cyc("fill", 1'b1, 1'b0, 1'b1, 1'b0, 8'(i));
      if (i == 8) chk("thr_rx_lag", 32'(bus.thre_trigger), 32'd0);
      if (i == 9) chk("thr_rx_rise", 32'(bus.thre_trigger), 32'd1);
    end
    chk("fill/full", 32'(bus.full), 32'd1);
    chk("fill/level16", 32'(bus.level), 32'd16);
    cyc("ovr", 1'b1, 1'b0, 1'b1, 1'b0, 8'h99);
    chk("ovr/pulse", 32'(bus.overrun), 32'd1);
    cyc("ovr_after", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("ovr/after", 32'(bus.overrun), 32'(STICKY));
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("drain%0d/head", i), 32'(bus.dout), 32'(i));
      cyc("drain", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    end
    chk("drain/empty", 32'(bus.empty), 32'd1);
    cyc("unr", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("unr/pulse", 32'(bus.underrun), 32'd1);
    cyc("flush1", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

    // Pointer wrap: push 10, pop 10, push 16; then simultaneous push+pop at full.
    for (int i = 0; i < 10; i++) cyc("wrap_push", 1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 10; i++) cyc("wrap_pop", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) cyc("wrap_fill", 1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
    chk("wrap/level16", 32'(bus.level), 32'd16);
    cyc("full_pp", 1'b1, 1'b0, 1'b1, 1'b1, 8'hEE);
    chk("full_pp/level", 32'(bus.level), 32'd16);
    chk("full_pp/no_ovr", 32'(bus.overrun), 32'd0);
    for (int i = 0; i < 16; i++) cyc("wrap_drain", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    cyc("empty_pp", 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A);
    chk("empty_pp/level", 32'(bus.level), 32'd1);
    chk("empty_pp/unr", 32'(bus.underrun), 32'd1);
    cyc("flush2", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

    // TX threshold 2: trigger high while level <= 2 (one cycle late).
    set_thr(THR_MODE_TX, 2);
    for (int i = 0; i < 4; i++) cyc("tx_push", 1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h50 + i));
    chk("thr_tx/lvl4", 32'(bus.thre_trigger), 32'd0);
    for (int i = 0; i < 3; i++) cyc("tx_pop", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("thr_tx/lvl1", 32'(bus.thre_trigger), 32'd1);

    // Flush together with push.
    for (int i = 0; i < 3; i++) cyc("pre_fl", 1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h61 + i));
    cyc("fl_push", 1'b1, 1'b1, 1'b1, 1'b0, 8'h7E);
    chk("fl_push/level", 32'(bus.level), 32'd0);
    chk("fl_push/empty", 32'(bus.empty), 32'd1);
    chk("fl_push/dout", 32'(bus.dout), 32'd0);

    // Asynchronous reset in the middle of a fill.
    set_thr(THR_MODE_RX, 8);
    for (int i = 0; i < 3; i++) cyc("pre_rst", 1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h90 + i));
    bus.push_in = 1'b1;
    bus.din     = 8'hAB;
    #2;
    rst = 1'b1;
    #1;
    chk_reset("arst");
    sb.delete();
    m_ovr = 1'b0;
    m_unr = 1'b0;
    @(negedge clk);
    bus.en = 1'b0; bus.push_in = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("arst/push_lost", 32'(bus.level), 32'd0);
    cyc("post_rst", 1'b1, 1'b0, 1'b1, 1'b0, 8'hC3);
    cyc("post_rst_pop", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
